// File: rtl/riscv_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | riscv_pkg                                                        |
// | Shared RV32I constants, ALU op encodings and forwarding helper.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package riscv_pkg;

  localparam int XLEN = 32;
  localparam int RA_W = 5;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  typedef enum logic [2:0] {
    ALU_ADD = 3'b000,
    ALU_SUB = 3'b001,
    ALU_OR  = 3'b010,
    ALU_ULT = 3'b011,
    ALU_AND = 3'b100,
    ALU_XOR = 3'b101,
    ALU_SLL = 3'b110,
    ALU_SRL = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    A_ZERO = 2'b00,
    A_RS1  = 2'b01,
    A_PC   = 2'b10
  } a_sel_e;

  typedef enum logic [1:0] {
    B_ZERO = 2'b00,
    B_RS2  = 2'b01,
    B_IMM  = 2'b10
  } b_sel_e;

  // x0 reads zero; the younger EX/MEM result wins over MEM/WB.
  function automatic logic [XLEN-1:0] fwd_select(
    input logic [RA_W-1:0] rs,
    input logic [XLEN-1:0] reg_data,
    input logic            ex_we,
    input logic [RA_W-1:0] ex_rd,
    input logic [XLEN-1:0] ex_data,
    input logic            wb_we,
    input logic [RA_W-1:0] wb_rd,
    input logic [XLEN-1:0] wb_val
  );
    if (rs == '0)
      return '0;
    else if (ex_we && (ex_rd == rs))
      return ex_data;
    else if (wb_we && (wb_rd == rs))
      return wb_val;
    else
      return reg_data;
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_decode                                                       |
// | Maps opcode/funct3/funct7b5 to ALU op, operand selects, illegal. |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_decode
  import riscv_pkg::*;
(
  input  logic [6:0] i_opcode,
  input  logic [2:0] i_funct3,
  input  logic       i_funct7b5,
  output alu_op_e    o_alu_op,
  output logic       o_illegal,
  output a_sel_e     o_a_sel,
  output b_sel_e     o_b_sel
);

  logic    w_is_r;
  logic    w_f3_ok;
  alu_op_e w_f3_op;

  assign w_is_r = (i_opcode == OP_R);

  always_comb begin
    w_f3_ok = 1'b1;
    w_f3_op = ALU_ADD;
    case (i_funct3)
      3'b000:  w_f3_op = (w_is_r && i_funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  w_f3_op = ALU_SLL;
      3'b011:  w_f3_op = ALU_ULT;
      3'b100:  w_f3_op = ALU_XOR;
      3'b110:  w_f3_op = ALU_OR;
      3'b111:  w_f3_op = ALU_AND;
      // funct7b5 set here selects arithmetic shift, which this ALU lacks
      3'b101: begin
        if (i_funct7b5) w_f3_ok = 1'b0;
        else            w_f3_op = ALU_SRL;
      end
      default: w_f3_ok = 1'b0;
    endcase
  end

  always_comb begin
    o_alu_op  = ALU_ADD;
    o_illegal = 1'b0;
    o_a_sel   = A_ZERO;
    o_b_sel   = B_ZERO;
    case (i_opcode)
      OP_R, OP_IMM: begin
        if (w_f3_ok) begin
          o_alu_op = w_f3_op;
          o_a_sel  = A_RS1;
          o_b_sel  = w_is_r ? B_RS2 : B_IMM;
        end else begin
          o_illegal = 1'b1;
        end
      end
      OP_LUI: begin
        o_b_sel = B_IMM;
      end
      OP_AUIPC: begin
        o_a_sel = A_PC;
        o_b_sel = B_IMM;
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/alu_operand_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | alu_operand_stage                                                |
// | Execute-entry register: decode, forwarding, load-use stall.      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module alu_operand_stage
  import riscv_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [RA_W-1:0] in_rs1,
  input  logic [RA_W-1:0] in_rs2,
  input  logic [RA_W-1:0] in_rd,
  input  logic [6:0]      in_opcode,
  input  logic [2:0]      in_funct3,
  input  logic            in_funct7b5,
  input  logic            exm_wr_en,
  input  logic            exm_is_load,
  input  logic [RA_W-1:0] exm_rd,
  input  logic [XLEN-1:0] exm_data,
  input  logic            wb_wr_en,
  input  logic [RA_W-1:0] wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [2:0]      alu_op,
  output logic [RA_W-1:0] out_rd,
  output logic            out_reg_write,
  output logic            illegal
);

  logic            r_vld;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_rs1_data;
  logic [XLEN-1:0] r_rs2_data;
  logic [XLEN-1:0] r_imm;
  logic [RA_W-1:0] r_rs1;
  logic [RA_W-1:0] r_rs2;
  logic [RA_W-1:0] r_rd;
  logic [6:0]      r_opcode;
  logic [2:0]      r_funct3;
  logic            r_funct7b5;

  alu_op_e         w_alu_op;
  logic            w_illegal;
  a_sel_e          w_a_sel;
  b_sel_e          w_b_sel;
  logic [XLEN-1:0] w_rs1_val;
  logic [XLEN-1:0] w_rs2_val;
  logic            w_hazard;
  logic            w_capture;
  logic            w_release;

  alu_decode u_decode (
    .i_opcode   (r_opcode),
    .i_funct3   (r_funct3),
    .i_funct7b5 (r_funct7b5),
    .o_alu_op   (w_alu_op),
    .o_illegal  (w_illegal),
    .o_a_sel    (w_a_sel),
    .o_b_sel    (w_b_sel)
  );

  assign w_rs1_val = fwd_select(r_rs1, r_rs1_data, exm_wr_en, exm_rd, exm_data,
                                wb_wr_en, wb_rd, wb_data);
  assign w_rs2_val = fwd_select(r_rs2, r_rs2_data, exm_wr_en, exm_rd, exm_data,
                                wb_wr_en, wb_rd, wb_data);

  // A load in EX/MEM has no data yet, so only sources actually read can stall.
  assign w_hazard = r_vld && exm_is_load && exm_wr_en && (exm_rd != '0) &&
                    (((w_a_sel == A_RS1) && (exm_rd == r_rs1)) ||
                     ((w_b_sel == B_RS2) && (exm_rd == r_rs2)));

  assign out_valid = r_vld && !w_hazard;
  assign w_release = out_valid && out_ready;
  assign in_ready  = !r_vld || w_release;
  assign w_capture = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld      <= 1'b0;
      r_pc       <= '0;
      r_rs1_data <= '0;
      r_rs2_data <= '0;
      r_imm      <= '0;
      r_rs1      <= '0;
      r_rs2      <= '0;
      r_rd       <= '0;
      r_opcode   <= '0;
      r_funct3   <= '0;
      r_funct7b5 <= 1'b0;
    end else begin
      if (flush)
        r_vld <= 1'b0;
      else if (w_capture)
        r_vld <= 1'b1;
      else if (w_release)
        r_vld <= 1'b0;

      if (w_capture) begin
        r_pc       <= in_pc;
        r_rs1_data <= in_rs1_data;
        r_rs2_data <= in_rs2_data;
        r_imm      <= in_imm;
        r_rs1      <= in_rs1;
        r_rs2      <= in_rs2;
        r_rd       <= in_rd;
        r_opcode   <= in_opcode;
        r_funct3   <= in_funct3;
        r_funct7b5 <= in_funct7b5;
      end
    end
  end

  always_comb begin
    alu_a = '0;
    case (w_a_sel)
      A_RS1:   alu_a = w_rs1_val;
      A_PC:    alu_a = r_pc;
      default: alu_a = '0;
    endcase
  end

  always_comb begin
    alu_b = '0;
    case (w_b_sel)
      B_RS2:   alu_b = w_rs2_val;
      B_IMM:   alu_b = r_imm;
      default: alu_b = '0;
    endcase
  end

  assign alu_op        = w_alu_op;
  assign out_rd        = r_rd;
  assign illegal       = r_vld && w_illegal;
  assign out_reg_write = r_vld && !w_illegal && (r_rd != '0);

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_alu_operand_stage                                             |
// | Scoreboard bench with a behavioural model of decode/forwarding.  |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_alu_operand_stage;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic        in_funct7b5;
  logic        exm_wr_en, exm_is_load, wb_wr_en;
  logic [4:0]  exm_rd, wb_rd;
  logic [31:0] exm_data, wb_data;
  logic [31:0] alu_a, alu_b;
  logic [2:0]  alu_op;
  logic [4:0]  out_rd;
  logic        out_reg_write, illegal;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .exm_wr_en(exm_wr_en), .exm_is_load(exm_is_load), .exm_rd(exm_rd), .exm_data(exm_data),
    .wb_wr_en(wb_wr_en), .wb_rd(wb_rd), .wb_data(wb_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
    .out_rd(out_rd), .out_reg_write(out_reg_write), .illegal(illegal)
  );

  // Instruction plus the forwarding environment it sees while held.
  typedef struct packed {
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic        f7b5;
    logic [31:0] pc, rs1d, rs2d, imm;
    logic [4:0]  rs1, rs2, rd;
    logic        exm_we;
    logic [4:0]  exm_rd;
    logic [31:0] exm_data;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic [1:0]  load_cycles;
  } instr_t;

  typedef struct packed {
    logic [31:0] a, b;
    logic [2:0]  op;
    logic [4:0]  rd;
    logic        rw, ill;
  } exp_t;

  int     n_checks = 0;
  int     n_fail   = 0;
  exp_t   sb[$];
  exp_t   e_m;
  instr_t held;
  logic   held_valid = 1'b0;
  int     load_left  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] opnd(input logic [4:0] rs, input logic [31:0] d, input instr_t i);
    if (rs == 5'd0) return 32'd0;
    if (i.exm_we && i.exm_rd == rs) return i.exm_data;
    if (i.wb_we && i.wb_rd == rs) return i.wb_data;
    return d;
  endfunction

  function automatic exp_t ref_out(input instr_t i);
    exp_t e;
    logic [2:0] tbl [8];
    tbl = '{3'd0, 3'd6, 3'd0, 3'd3, 3'd5, 3'd7, 3'd2, 3'd4};
    e = '0;
    e.rd = i.rd;
    if (i.opcode == OP_R || i.opcode == OP_IMM) begin
      e.ill = (i.f3 == 3'd2) || (i.f3 == 3'd5 && i.f7b5);
      e.op  = tbl[i.f3];
      if (i.opcode == OP_R && i.f3 == 3'd0 && i.f7b5) e.op = 3'd1;
      e.a = opnd(i.rs1, i.rs1d, i);
      e.b = (i.opcode == OP_R) ? opnd(i.rs2, i.rs2d, i) : i.imm;
    end else if (i.opcode == OP_LUI) begin
      e.a = 32'd0; e.b = i.imm;
    end else if (i.opcode == OP_AUIPC) begin
      e.a = i.pc; e.b = i.imm;
    end else begin
      e.ill = 1'b1;
    end
    if (e.ill) e.op = 3'd0;
    e.rw = !e.ill && (i.rd != 5'd0);
    return e;
  endfunction

  function automatic instr_t mk(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                input logic [31:0] d1, input logic [31:0] d2,
                                input logic [31:0] imm, input logic [31:0] pc);
    instr_t i;
    i = '0;
    i.opcode = op; i.f3 = f3; i.f7b5 = f7;
    i.rs1 = rs1; i.rs2 = rs2; i.rd = rd;
    i.rs1d = d1; i.rs2d = d2; i.imm = imm; i.pc = pc;
    return i;
  endfunction

  function automatic instr_t rand_instr(input logic allow_load);
    instr_t i;
    int     sel;
    logic   u1, u2, legal;
    sel = $urandom_range(0, 9);
    i.opcode = (sel < 4) ? OP_R : (sel < 7) ? OP_IMM : (sel == 7) ? OP_LUI :
               (sel == 8) ? OP_AUIPC : 7'($urandom);
    i.f3 = 3'($urandom); i.f7b5 = 1'($urandom);
    i.pc = $urandom; i.rs1d = $urandom; i.rs2d = $urandom; i.imm = $urandom;
    i.rs1 = 5'($urandom_range(0, 7)); i.rs2 = 5'($urandom_range(0, 7));
    i.rd  = 5'($urandom_range(0, 7));
    i.exm_we = 1'($urandom); i.exm_rd = 5'($urandom_range(0, 7)); i.exm_data = $urandom;
    i.wb_we  = 1'($urandom); i.wb_rd  = 5'($urandom_range(0, 7)); i.wb_data  = $urandom;
    i.load_cycles = 2'd0;
    legal = !ref_out(i).ill;
    u1 = legal && (i.opcode == OP_R || i.opcode == OP_IMM) && (i.rs1 != 5'd0);
    u2 = legal && (i.opcode == OP_R) && (i.rs2 != 5'd0);
    if (allow_load && ($urandom_range(0, 4) == 0) && (u1 || u2)) begin
      i.exm_we = 1'b1;
      i.exm_rd = (u2 && (!u1 || $urandom_range(0, 1) == 1)) ? i.rs2 : i.rs1;
      i.load_cycles = 2'($urandom_range(1, 2));
    end
    return i;
  endfunction

  // One clock of stimulus plus the handshake model for the upcoming edge.
  task automatic cycle(input logic v, input instr_t ins, input logic ordy, input logic fl);
    logic exp_ov, exp_ir, fire_in, fire_out;
    @(posedge clk); #1;
    in_valid = v; flush = fl; out_ready = ordy;
    in_opcode = ins.opcode; in_funct3 = ins.f3; in_funct7b5 = ins.f7b5;
    in_pc = ins.pc; in_rs1_data = ins.rs1d; in_rs2_data = ins.rs2d; in_imm = ins.imm;
    in_rs1 = ins.rs1; in_rs2 = ins.rs2; in_rd = ins.rd;
    if (held_valid) begin
      exm_wr_en = held.exm_we; exm_rd = held.exm_rd; exm_data = held.exm_data;
      wb_wr_en = held.wb_we; wb_rd = held.wb_rd; wb_data = held.wb_data;
      exm_is_load = (load_left > 0);
    end else begin
      exm_wr_en = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
      wb_wr_en = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_data = $urandom;
      exm_is_load = 1'($urandom);
    end
    @(negedge clk);
    exp_ov = held_valid && (load_left == 0);
    exp_ir = !held_valid || (exp_ov && ordy);
    chk("out_valid", 32'(out_valid), 32'(exp_ov));
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    #1;
    fire_out = exp_ov && ordy;
    fire_in  = v && exp_ir && !fl;
    if (fl) begin
      if (held_valid && !fire_out) void'(sb.pop_back());
      held_valid = 1'b0;
    end else if (fire_in) begin
      sb.push_back(ref_out(ins));
      held = ins; held_valid = 1'b1; load_left = int'(ins.load_cycles);
    end else if (fire_out) begin
      held_valid = 1'b0;
    end else if (held_valid && load_left > 0) begin
      load_left--;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (sb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL scoreboard_empty: got out_valid=1 expected no pending result");
      end else begin
        e_m = sb[0];
        chk("alu_op", 32'(alu_op), 32'(e_m.op));
        chk("out_rd", 32'(out_rd), 32'(e_m.rd));
        chk("illegal", 32'(illegal), 32'(e_m.ill));
        chk("out_reg_write", 32'(out_reg_write), 32'(e_m.rw));
        if (!e_m.ill) begin
          chk("alu_a", alu_a, e_m.a);
          chk("alu_b", alu_b, e_m.b);
        end
        if (out_ready) e_m = sb.pop_front();
      end
    end
  end

  task automatic chk_reset_values();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_b", alu_b, 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'd0);
    chk("rst_out_rd", 32'(out_rd), 32'd0);
    chk("rst_reg_write", 32'(out_reg_write), 32'd0);
    chk("rst_illegal", 32'(illegal), 32'd0);
  endtask

  initial begin
    instr_t t, u;
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1 = '0; in_rs2 = '0; in_rd = '0; in_opcode = '0; in_funct3 = '0; in_funct7b5 = 1'b0;
    exm_wr_en = 1'b0; exm_is_load = 1'b0; exm_rd = '0; exm_data = '0;
    wb_wr_en = 1'b0; wb_rd = '0; wb_data = '0;
    repeat (2) @(posedge clk);
    #1 chk_reset_values();
    @(negedge clk); rst = 1'b0;

    // ADD then SUB with rs1=5, rs2=3
    t = mk(OP_R, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd3, 32'd0, 32'd0);
    cycle(1'b1, t, 1'b1, 1'b0);
    t.f7b5 = 1'b1;
    cycle(1'b1, t, 1'b1, 1'b0);

    // Forwarding priority, WB fallback, x0
    t = mk(OP_R, 3'd6, 1'b0, 5'd7, 5'd2, 5'd9, 32'hdead, 32'h4, 32'd0, 32'd0);
    t.exm_we = 1'b1; t.exm_rd = 5'd7; t.exm_data = 32'h11;
    t.wb_we = 1'b1; t.wb_rd = 5'd7; t.wb_data = 32'h22;
    cycle(1'b1, t, 1'b1, 1'b0);
    t.exm_we = 1'b0;
    cycle(1'b1, t, 1'b1, 1'b0);
    t.rs1 = 5'd0; t.exm_we = 1'b1; t.exm_rd = 5'd0; t.exm_data = 32'h55;
    cycle(1'b1, t, 1'b1, 1'b0);

    // Load-use on rs2=4 for one cycle
    t = mk(OP_R, 3'd0, 1'b0, 5'd1, 5'd4, 5'd5, 32'h1, 32'h2, 32'd0, 32'd0);
    t.exm_we = 1'b1; t.exm_rd = 5'd4; t.exm_data = 32'h44;
    t.wb_we = 1'b1; t.wb_rd = 5'd1; t.wb_data = 32'h77; t.load_cycles = 2'd1;
    cycle(1'b1, t, 1'b1, 1'b0);
    u = rand_instr(1'b0);
    cycle(1'b1, u, 1'b1, 1'b0);
    cycle(1'b0, u, 1'b1, 1'b0);

    // Back-pressure for 3 cycles, then a back-to-back stream
    t = rand_instr(1'b0);
    cycle(1'b1, t, 1'b0, 1'b0);
    for (int k = 0; k < 3; k++) cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) cycle(1'b1, rand_instr(1'b0), 1'b1, 1'b0);

    // SRA, SLT, LUI, AUIPC
    cycle(1'b1, mk(OP_R, 3'd5, 1'b1, 5'd1, 5'd2, 5'd3, 32'h8, 32'h1, 32'd0, 32'd0), 1'b1, 1'b0);
    cycle(1'b1, mk(OP_IMM, 3'd2, 1'b0, 5'd1, 5'd2, 5'd3, 32'h8, 32'h1, 32'h5, 32'd0), 1'b1, 1'b0);
    cycle(1'b1, mk(OP_LUI, 3'd0, 1'b0, 5'd6, 5'd2, 5'd3, 32'h8, 32'h1, 32'h12345000, 32'h40), 1'b1, 1'b0);
    cycle(1'b1, mk(OP_AUIPC, 3'd0, 1'b0, 5'd1, 5'd2, 5'd3, 32'h8, 32'h1, 32'h2000, 32'h100), 1'b1, 1'b0);
    cycle(1'b0, t, 1'b1, 1'b0);

    // Flush with in_valid on an empty stage, then flush of a held instruction
    cycle(1'b1, rand_instr(1'b0), 1'b1, 1'b1);
    cycle(1'b0, t, 1'b1, 1'b0);
    cycle(1'b1, rand_instr(1'b0), 1'b0, 1'b0);
    cycle(1'b0, t, 1'b0, 1'b1);
    cycle(1'b0, t, 1'b1, 1'b0);

    for (int k = 0; k < 400; k++)
      cycle(1'($urandom_range(0, 3) != 0), rand_instr(1'b1),
            1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 24) == 0));
    for (int k = 0; k < 8 && held_valid; k++) cycle(1'b0, t, 1'b1, 1'b0);

    // Asynchronous reset in the middle of a load-use stall
    t = mk(OP_R, 3'd7, 1'b0, 5'd3, 5'd4, 5'd6, 32'habc, 32'h123, 32'd0, 32'h80);
    t.exm_we = 1'b1; t.exm_rd = 5'd3; t.exm_data = 32'h99; t.load_cycles = 2'd3;
    cycle(1'b1, t, 1'b1, 1'b0);
    cycle(1'b0, t, 1'b1, 1'b0);
    @(posedge clk); #3 rst = 1'b1;
    #1 chk_reset_values();
    held_valid = 1'b0; load_left = 0; sb.delete();
    @(negedge clk); @(posedge clk); #2 rst = 1'b0;
    for (int k = 0; k < 40; k++) cycle(1'b1, rand_instr(1'b1), 1'b1, 1'b0);
    for (int k = 0; k < 8 && held_valid; k++) cycle(1'b0, t, 1'b1, 1'b0);

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_operand_stage.md
# alu_operand_stage

Execute-entry pipeline stage that sits directly upstream of the 3-bit-op ALU. It captures one decoded RV32I instruction per handshake and maps opcode/funct fields to the ALU's operation code. It selects ALU operands, with EX/MEM and MEM/WB forwarding applied, and holds its output under load-use hazards and downstream back-pressure. Flush support is for branch redirect.

## Interface
- XLEN, 32, datapath width
- RA_W, 5, register address width
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- flush  in  1  drop held instruction (branch redirect)
- in_valid / in_ready  in / out  1  upstream handshake from decode
- in_pc, in_rs1_data, in_rs2_data, in_imm  in  XLEN  decoded instruction fields
- in_rs1, in_rs2, in_rd  in  RA_W  register addresses
- in_opcode  in  7; in_funct3  in  3; in_funct7b5  in  1
- exm_wr_en, exm_is_load  in  1; exm_rd  in  RA_W; exm_data  in  XLEN  EX/MEM writeback source
- wb_wr_en  in  1; wb_rd  in  RA_W; wb_data  in  XLEN  MEM/WB writeback source
- out_valid  out  1; out_ready  in  1  downstream handshake
- alu_a, alu_b  out  XLEN; alu_op  out  3  ALU operands and operation
- out_rd  out  RA_W; out_reg_write  out  1; illegal  out  1

## Operation
- ALU op codes: 000 add, 001 sub, 010 or, 011 unsigned less-than, 100 and, 101 xor, 110 sll, 111 srl.
- R-type (0110011), by funct3:
  - 000: sub if funct7b5 is 1, else add.
  - 110 → or; 011 → ult; 111 → and; 100 → xor; 001 → sll.
  - 101: srl if funct7b5 is 0.
  - Operands: A = rs1, B = rs2.
- I-type (0010011): same funct3 map.
  - 000 is always add.
  - 101 requires funct7b5 = 0.
  - Operands: A = rs1, B = imm.
- LUI (0110111): A = 0, B = imm, add.
- AUIPC (0010111): A = pc, B = imm, add.
- Unsupported encodings set illegal = 1, out_reg_write = 0 and alu_op = 000:
  - funct3 010 (signed slt);
  - funct3 101 with funct7b5 = 1 (sra);
  - any other opcode.
- out_reg_write = 1 for legal instructions with rd ≠ 0.
- Forwarding applies per source, to rs1 and to rs2 when used:
  - Register x0 always reads 0.
  - Else if exm_wr_en and exm_rd == rs, use exm_data. EX/MEM has priority.
  - Else if wb_wr_en and wb_rd == rs, use wb_data.
  - Else use the captured register data.
- Load-use hazard: exm_is_load, exm_wr_en, exm_rd == a used rs, and rs ≠ 0.
  - While the hazard holds: out_valid = 0 and the stage holds its contents.

## Timing
- in_ready = !vld_q || (out_valid && out_ready).
- Capture on in_valid && in_ready. out_valid can first assert one cycle after capture.
- out_valid = vld_q && !hazard.
- Forwarding and decode are combinational from the registered fields and the current forwarding inputs. They add no latency.
- Outputs must stay stable while out_valid && !out_ready.
- flush is synchronous. It clears vld_q next edge and takes priority over capture: with flush and in_valid in the same cycle, nothing is captured.
- Accept and release in the same cycle is allowed, giving full throughput of 1 instruction/cycle.
- Async rst clears all registers immediately. Values during reset:
  - out_valid = 0 and in_ready = 1.
  - alu_a = 0, alu_b = 0, alu_op = 000, out_rd = 0.
  - out_reg_write = 0 and illegal = 0. illegal and out_reg_write are gated by vld_q.
- Reset mid-hazard discards the held instruction.

## Structure
- Shared package riscv_pkg holds:
  - XLEN;
  - the opcode constants OP_R, OP_IMM, OP_LUI, OP_AUIPC;
  - the ALU op encodings ALU_ADD…ALU_SRL.
- Sub-module alu_decode is combinational: opcode, funct3, funct7b5 → alu_op, illegal, a_sel, b_sel.
- The top level holds the pipeline register, forwarding muxes, hazard detection and handshake.

## Test plan
- ADD/SUB: R-type funct3 000 with rs1 = 5 and rs2 = 3.
  - funct7b5 = 0: alu_op = 000, A = 5, B = 3, out_valid one cycle after accept.
  - funct7b5 = 1: alu_op = 001.
- Forwarding priority: exm_rd = wb_rd = rs1 = 7, exm_data = 0x11, wb_data = 0x22 → alu_a = 0x11.
  - Drop exm_wr_en → alu_a = 0x22.
  - rs1 = 0 with exm_rd = 0 → alu_a = 0.
- Load-use: exm_is_load with exm_rd = rs2 = 4 for 1 cycle → out_valid low for that cycle, then high with exm_data/wb_data forwarded. in_ready = 0 throughout the hold.
- Back-pressure and throughput: out_ready held 0 for 3 cycles → outputs stable and no new capture. Back-to-back stream with out_ready = 1 → one result per cycle.
- Illegal and special ops: SRA and funct3 010 → illegal = 1, out_reg_write = 0. LUI imm 0x12345000 → A = 0, B = imm. AUIPC pc 0x100 → A = 0x100.
- Flush and reset: flush with in_valid in the same cycle → no capture and out_valid = 0 next cycle. rst asserted asynchronously mid-stall → all outputs at reset values before the next clk edge.
